// File: rtl/program_memory_pkg.sv
// Shared definitions for the writable program store: opcode encodings, the NOP fill word,
// default geometry and the controller state encoding.
package program_memory_pkg;

   localparam int DEF_INSTR_W = 28;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DEPTH   = 256;

   localparam logic [3:0] OP_NOP = 4'h0;

   // The NOP carries a fixed operand payload so a decoder can tell a filled word from blank RAM
   localparam logic [DEF_INSTR_W-1:0] NOP_DEFAULT = {OP_NOP, 24'd4000};

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2
   } state_t;

endpackage

// File: rtl/program_memory_if.sv
// Fetch and loader signals of the program store; the memory side uses the slave modport,
// the fetch unit and program loader use the master modport.
interface program_memory_if
   import program_memory_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W
);

   logic [ADDR_W-1:0]  iAddress;
   logic [INSTR_W-1:0] oInstruction;
   logic               oInstructionValid;
   logic               iLoadStart;
   logic [ADDR_W-1:0]  iLoadBase;
   logic [ADDR_W:0]    iLoadCount;
   logic [INSTR_W-1:0] iLoadData;
   logic               iLoadValid;
   logic               oLoadReady;
   logic               oLoading;
   logic               oLoadDone;
   logic               oLoadError;

   modport master (
      output iAddress, iLoadStart, iLoadBase, iLoadCount, iLoadData, iLoadValid,
      input  oInstruction, oInstructionValid, oLoadReady, oLoading, oLoadDone, oLoadError
   );

   modport slave (
      input  iAddress, iLoadStart, iLoadBase, iLoadCount, iLoadData, iLoadValid,
      output oInstruction, oInstructionValid, oLoadReady, oLoading, oLoadDone, oLoadError
   );

endinterface

// File: rtl/program_memory_ram.sv
// Simple dual-port storage array with a registered read-first port; no reset so that
// synthesis can map it onto block RAM.
module program_memory_ram #(
   parameter int DEPTH   = 256,
   parameter int INSTR_W = 28,
   parameter int IDX_W   = 8
) (
   input  logic               Clock,
   input  logic               writeEnable,
   input  logic [IDX_W-1:0]   writeAddr,
   input  logic [INSTR_W-1:0] writeData,
   input  logic [IDX_W-1:0]   readAddr,
   output logic [INSTR_W-1:0] readData
);

   logic [INSTR_W-1:0] mem [DEPTH];

   // Both ports update on the same edge, so a same-address read returns the old word
   always_ff @(posedge Clock) begin
      if (writeEnable) begin
         mem[writeAddr] <= writeData;
      end
      readData <= mem[readAddr];
   end

endmodule

// File: rtl/program_memory.sv
// Writable program store: self-fills with NOPs after reset, accepts run-time program loads
// over a valid/ready port and serves the fetch unit with one cycle of read latency.
module program_memory
   import program_memory_pkg::*;
#(
   parameter int                 INSTR_W  = DEF_INSTR_W,
   parameter int                 ADDR_W   = DEF_ADDR_W,
   parameter int                 DEPTH    = DEF_DEPTH,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_DEFAULT
) (
   input  logic            Clock,
   input  logic            Reset,
   program_memory_if.slave bus
);

   localparam int                 IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W:0]    DEPTH_A1 = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W+1:0]  DEPTH_A2 = (ADDR_W+2)'(DEPTH);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]    ONE_LEFT = (ADDR_W+1)'(1);

   state_t              state;
   state_t              nextState;
   logic [IDX_W-1:0]    fillCount;
   logic [IDX_W-1:0]    writePtr;
   logic [ADDR_W:0]     remaining;
   logic [ADDR_W+1:0]   loadEnd;

   logic                ramWe;
   logic [IDX_W-1:0]    ramWaddr;
   logic [INSTR_W-1:0]  ramWdata;
   logic [INSTR_W-1:0]  ramRdata;

   logic                accept;
   logic                lastAccept;
   logic                startEmpty;
   logic                startOk;
   logic                startReject;

   logic                validQ;
   logic                inRangeQ;
   logic                doneQ;
   logic                errorQ;

   // State register of the fill / idle / load controller
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= CLEAR;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode, RAM write-port steering and load request classification
   always_comb begin
      nextState   = state;
      ramWe       = 1'b0;
      ramWaddr    = fillCount;
      ramWdata    = NOP_WORD;
      accept      = 1'b0;
      lastAccept  = 1'b0;
      startEmpty  = 1'b0;
      startOk     = 1'b0;
      startReject = 1'b0;
      loadEnd     = {2'b00, bus.iLoadBase} + {1'b0, bus.iLoadCount};

      case (state)
         CLEAR: begin
            ramWe = 1'b1;
            if (fillCount == LAST_IDX) begin
               nextState = IDLE;
            end
            startReject = bus.iLoadStart;
         end
         IDLE: begin
            if (bus.iLoadStart) begin
               if (bus.iLoadCount == '0) begin
                  startEmpty = 1'b1;
               end else if (loadEnd > DEPTH_A2) begin
                  startReject = 1'b1;
               end else begin
                  startOk   = 1'b1;
                  nextState = LOAD;
               end
            end
         end
         LOAD: begin
            accept   = bus.iLoadValid;
            ramWe    = accept;
            ramWaddr = writePtr;
            ramWdata = bus.iLoadData;
            if (accept && (remaining == ONE_LEFT)) begin
               lastAccept = 1'b1;
               nextState  = IDLE;
            end
            startReject = bus.iLoadStart;
         end
         default: begin
            nextState = CLEAR;
         end
      endcase
   end

   // Fill counter, load pointer and the registered status / read qualifiers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         fillCount <= '0;
         writePtr  <= '0;
         remaining <= '0;
         validQ    <= 1'b0;
         inRangeQ  <= 1'b0;
         doneQ     <= 1'b0;
         errorQ    <= 1'b0;
      end else begin
         if (state == CLEAR) begin
            fillCount <= fillCount + 1'b1;
         end
         if (startOk) begin
            writePtr  <= bus.iLoadBase[IDX_W-1:0];
            remaining <= bus.iLoadCount;
         end else if (accept) begin
            writePtr  <= writePtr + 1'b1;
            remaining <= remaining - 1'b1;
         end
         validQ   <= (nextState == IDLE);
         inRangeQ <= ({1'b0, bus.iAddress} < DEPTH_A1);
         doneQ    <= startEmpty || lastAccept;
         errorQ   <= startReject;
      end
   end

   program_memory_ram #(
      .DEPTH   (DEPTH),
      .INSTR_W (INSTR_W),
      .IDX_W   (IDX_W)
   ) u_ram (
      .Clock       (Clock),
      .writeEnable (ramWe && !Reset),
      .writeAddr   (ramWaddr),
      .writeData   (ramWdata),
      .readAddr    (bus.iAddress[IDX_W-1:0]),
      .readData    (ramRdata)
   );

   assign bus.oInstruction      = (validQ && inRangeQ) ? ramRdata : NOP_WORD;
   assign bus.oInstructionValid = validQ;
   assign bus.oLoadReady        = (state == LOAD);
   assign bus.oLoading          = (state != IDLE);
   assign bus.oLoadDone         = doneQ;
   assign bus.oLoadError        = errorQ;

endmodule

// File: tb/tb_program_memory.sv
// Directed self-checking bench for program_memory: NOP fill, loads, range rejection,
// out-of-range fetch, reset abort and busy-start rejection.
module tb_program_memory;

   localparam logic [27:0] NOP = 28'h0000FA0;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   assertCount = 0;
   int   failCount   = 0;

   program_memory_if #(.ADDR_W(16), .INSTR_W(28)) bus ();

   program_memory #(
      .INSTR_W (28),
      .ADDR_W  (16),
      .DEPTH   (256)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic readWord(input logic [15:0] a, output logic [27:0] d, output logic v);
      bus.iAddress = a;
      tick();
      d = bus.oInstruction;
      v = bus.oInstructionValid;
   endtask

   task automatic startLoad(input logic [15:0] base, input logic [16:0] count);
      bus.iLoadBase  = base;
      bus.iLoadCount = count;
      bus.iLoadStart = 1'b1;
      tick();
      bus.iLoadStart = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      logic [27:0] d;
      logic v;
      Reset = 1'b1;
      repeat (3) tick();
      Reset = 1'b0;
      assertCount++;
      if ({bus.oLoading, bus.oInstructionValid, bus.oLoadReady, bus.oLoadDone, bus.oLoadError} !== 5'b10000) begin
         failCount++;
         $display("[TB] FAIL reset_flags: got %b expected 10000",
                  {bus.oLoading, bus.oInstructionValid, bus.oLoadReady, bus.oLoadDone, bus.oLoadError});
      end
      assertCount++;
      if (bus.oInstruction !== NOP) begin
         failCount++;
         $display("[TB] FAIL reset_instr: got %h expected %h", bus.oInstruction, NOP);
      end
      n = 0;
      while (bus.oLoading === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      assertCount++;
      if (n !== 256) begin
         failCount++;
         $display("[TB] FAIL clear_cycles: got %0d expected 256", n);
      end
      assertCount++;
      if (bus.oInstructionValid !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL valid_after_clear: got %b expected 1", bus.oInstructionValid);
      end
      readWord(16'd0, d, v);
      assertCount++;
      if ({v, d} !== {1'b1, NOP}) begin
         failCount++;
         $display("[TB] FAIL clear_read0: got %b/%h expected 1/%h", v, d, NOP);
      end
      readWord(16'd100, d, v);
      assertCount++;
      if ({v, d} !== {1'b1, NOP}) begin
         failCount++;
         $display("[TB] FAIL clear_read100: got %b/%h expected 1/%h", v, d, NOP);
      end
      readWord(16'd255, d, v);
      assertCount++;
      if ({v, d} !== {1'b1, NOP}) begin
         failCount++;
         $display("[TB] FAIL clear_read255: got %b/%h expected 1/%h", v, d, NOP);
      end
   endtask

   task automatic test_load_basic();
      logic [27:0] d;
      logic v;
      logic [27:0] words [3];
      words[0] = 28'hA1B2C3D;
      words[1] = 28'h1234567;
      words[2] = 28'h7654321;
      startLoad(16'd9, 17'd3);
      assertCount++;
      if ({bus.oLoadReady, bus.oLoading, bus.oInstructionValid} !== 3'b110) begin
         failCount++;
         $display("[TB] FAIL load_state: got %b expected 110",
                  {bus.oLoadReady, bus.oLoading, bus.oInstructionValid});
      end
      bus.iLoadValid = 1'b1;
      bus.iLoadData  = words[0];
      tick();
      bus.iLoadValid = 1'b0;
      tick();
      assertCount++;
      if ({bus.oLoadDone, bus.oLoadReady} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL load_gap: got done/ready %b expected 01", {bus.oLoadDone, bus.oLoadReady});
      end
      bus.iLoadValid = 1'b1;
      bus.iLoadData  = words[1];
      tick();
      bus.iLoadData  = words[2];
      bus.iAddress   = 16'd11;
      tick();
      bus.iLoadValid = 1'b0;
      assertCount++;
      if ({bus.oLoadDone, bus.oInstructionValid, bus.oInstruction} !== {2'b11, NOP}) begin
         failCount++;
         $display("[TB] FAIL load_done_readfirst: got %b/%b/%h expected 1/1/%h",
                  bus.oLoadDone, bus.oInstructionValid, bus.oInstruction, NOP);
      end
      tick();
      assertCount++;
      if (bus.oLoadDone !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL load_done_pulse: got %b expected 0", bus.oLoadDone);
      end
      for (int i = 0; i < 3; i++) begin
         readWord(16'(9 + i), d, v);
         assertCount++;
         if ({v, d} !== {1'b1, words[i]}) begin
            failCount++;
            $display("[TB] FAIL load_read%0d: got %b/%h expected 1/%h", 9 + i, v, d, words[i]);
         end
      end
      readWord(16'd8, d, v);
      assertCount++;
      if (d !== NOP) begin
         failCount++;
         $display("[TB] FAIL load_read8: got %h expected %h", d, NOP);
      end
   endtask

   task automatic test_range_error();
      logic [27:0] d;
      logic v;
      startLoad(16'd250, 17'd7);
      assertCount++;
      if ({bus.oLoadError, bus.oLoading, bus.oLoadDone} !== 3'b100) begin
         failCount++;
         $display("[TB] FAIL range_reject: got err/loading/done %b expected 100",
                  {bus.oLoadError, bus.oLoading, bus.oLoadDone});
      end
      tick();
      assertCount++;
      if (bus.oLoadError !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL range_err_pulse: got %b expected 0", bus.oLoadError);
      end
      readWord(16'd250, d, v);
      assertCount++;
      if (d !== NOP) begin
         failCount++;
         $display("[TB] FAIL range_untouched: got %h expected %h", d, NOP);
      end
      startLoad(16'd249, 17'd7);
      assertCount++;
      if ({bus.oLoadError, bus.oLoadReady} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL range_accept: got err/ready %b expected 01", {bus.oLoadError, bus.oLoadReady});
      end
      bus.iLoadValid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.iLoadData = 28'h0B00000 + 28'(i);
         tick();
      end
      bus.iLoadValid = 1'b0;
      assertCount++;
      if ({bus.oLoadDone, bus.oLoading} !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL range_fill_done: got done/loading %b expected 10", {bus.oLoadDone, bus.oLoading});
      end
      readWord(16'd249, d, v);
      assertCount++;
      if (d !== 28'h0B00000) begin
         failCount++;
         $display("[TB] FAIL range_read249: got %h expected 0b00000", d);
      end
      readWord(16'd255, d, v);
      assertCount++;
      if (d !== 28'h0B00006) begin
         failCount++;
         $display("[TB] FAIL range_read255: got %h expected 0b00006", d);
      end
   endtask

   task automatic test_out_of_range_read();
      logic [27:0] d;
      logic v;
      readWord(16'd265, d, v);
      assertCount++;
      if ({v, d} !== {1'b1, NOP}) begin
         failCount++;
         $display("[TB] FAIL oor_read265: got %b/%h expected 1/%h", v, d, NOP);
      end
      readWord(16'hFFF9, d, v);
      assertCount++;
      if ({v, d} !== {1'b1, NOP}) begin
         failCount++;
         $display("[TB] FAIL oor_readfff9: got %b/%h expected 1/%h", v, d, NOP);
      end
   endtask

   task automatic test_reset_mid_load();
      int n;
      int doneSeen;
      logic [27:0] d;
      logic v;
      startLoad(16'd20, 17'd5);
      bus.iLoadValid = 1'b1;
      bus.iLoadData  = 28'hC000001;
      tick();
      bus.iLoadData  = 28'hC000002;
      tick();
      bus.iLoadValid = 1'b0;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      assertCount++;
      if ({bus.oLoadDone, bus.oLoading, bus.oLoadReady} !== 3'b010) begin
         failCount++;
         $display("[TB] FAIL midload_reset: got done/loading/ready %b expected 010",
                  {bus.oLoadDone, bus.oLoading, bus.oLoadReady});
      end
      n = 0;
      doneSeen = 0;
      while (bus.oLoading === 1'b1 && n < 300) begin
         if (bus.oLoadDone === 1'b1) doneSeen++;
         n++;
         tick();
      end
      assertCount++;
      if (n !== 256 || doneSeen !== 0) begin
         failCount++;
         $display("[TB] FAIL midload_clear: got %0d cycles %0d dones expected 256 cycles 0 dones", n, doneSeen);
      end
      readWord(16'd20, d, v);
      assertCount++;
      if (d !== NOP) begin
         failCount++;
         $display("[TB] FAIL midload_read20: got %h expected %h", d, NOP);
      end
      readWord(16'd21, d, v);
      assertCount++;
      if (d !== NOP) begin
         failCount++;
         $display("[TB] FAIL midload_read21: got %h expected %h", d, NOP);
      end
      readWord(16'd9, d, v);
      assertCount++;
      if ({v, d} !== {1'b1, NOP}) begin
         failCount++;
         $display("[TB] FAIL midload_read9: got %b/%h expected 1/%h", v, d, NOP);
      end
   endtask

   task automatic test_zero_and_busy();
      logic [27:0] d;
      logic v;
      startLoad(16'd5, 17'd0);
      assertCount++;
      if ({bus.oLoadDone, bus.oLoading, bus.oLoadError} !== 3'b100) begin
         failCount++;
         $display("[TB] FAIL zero_done: got done/loading/err %b expected 100",
                  {bus.oLoadDone, bus.oLoading, bus.oLoadError});
      end
      tick();
      assertCount++;
      if (bus.oLoadDone !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL zero_done_pulse: got %b expected 0", bus.oLoadDone);
      end
      readWord(16'd5, d, v);
      assertCount++;
      if (d !== NOP) begin
         failCount++;
         $display("[TB] FAIL zero_read5: got %h expected %h", d, NOP);
      end
      startLoad(16'd30, 17'd2);
      bus.iLoadBase  = 16'd0;
      bus.iLoadCount = 17'd1;
      bus.iLoadStart = 1'b1;
      bus.iLoadValid = 1'b1;
      bus.iLoadData  = 28'hD00000A;
      tick();
      bus.iLoadStart = 1'b0;
      assertCount++;
      if ({bus.oLoadError, bus.oLoading, bus.oLoadDone} !== 3'b110) begin
         failCount++;
         $display("[TB] FAIL busy_reject: got err/loading/done %b expected 110",
                  {bus.oLoadError, bus.oLoading, bus.oLoadDone});
      end
      bus.iLoadData = 28'hD00000B;
      tick();
      bus.iLoadValid = 1'b0;
      assertCount++;
      if ({bus.oLoadDone, bus.oLoadError, bus.oLoading} !== 3'b100) begin
         failCount++;
         $display("[TB] FAIL busy_complete: got done/err/loading %b expected 100",
                  {bus.oLoadDone, bus.oLoadError, bus.oLoading});
      end
      readWord(16'd30, d, v);
      assertCount++;
      if (d !== 28'hD00000A) begin
         failCount++;
         $display("[TB] FAIL busy_read30: got %h expected d00000a", d);
      end
      readWord(16'd31, d, v);
      assertCount++;
      if (d !== 28'hD00000B) begin
         failCount++;
         $display("[TB] FAIL busy_read31: got %h expected d00000b", d);
      end
      readWord(16'd0, d, v);
      assertCount++;
      if (d !== NOP) begin
         failCount++;
         $display("[TB] FAIL busy_read0: got %h expected %h", d, NOP);
      end
   endtask

   initial begin
      bus.iAddress   = '0;
      bus.iLoadStart = 1'b0;
      bus.iLoadBase  = '0;
      bus.iLoadCount = '0;
      bus.iLoadData  = '0;
      bus.iLoadValid = 1'b0;
      test_reset();
      test_load_basic();
      test_range_error();
      test_out_of_range_read();
      test_reset_mid_load();
      test_zero_and_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
